// File: rtl/mips_loader_pkg.sv
// mips_loader_pkg: shared FSM states, word geometry and checksum type for the program loader
package mips_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHK,
        S_BOOT,
        S_RUN,
        S_ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [7:0] csum_t;

endpackage

// File: rtl/loader_word_packer.sv
// loader_word_packer: shifts accepted bytes into a big-endian 32-bit word and flags the 4th byte
module loader_word_packer
    import mips_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [7:0]  in_data,
    input  logic        accept,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0] cnt;

    assign word_ready = accept && cnt == 2'(BYTES_PER_WORD - 1);

    // first byte ends up in [31:24] after four shifts; clear realigns on a new load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (accept) begin
            word <= {word[23:0], in_data};
            cnt  <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/mips_program_loader.sv
// mips_program_loader: streams a byte image into MIPS instruction memory then releases the core (optional MIPS_LOADER_CHECKSUM_EN)
module mips_program_loader
    import mips_loader_pkg::*;
#(
    parameter int          ADDR_W   = 11,
    parameter logic [31:0] START_PC = 32'h0000_0000
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       instructionInput,
    output logic              instructionWriteEnable,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [31:0]       PC,
    output logic              PC_set,
    output logic              busy,
    output logic              running,
    output logic              error
);

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};
`ifdef MIPS_LOADER_CHECKSUM_EN
    localparam state_t S_DONE = S_CHK;
`else
    localparam state_t S_DONE = S_BOOT;
`endif

    state_t          state, state_nx;
    logic [ADDR_W:0] len_q, word_cnt, word_nx;
    logic            accept, byte_acc, start_ok, word_ready;

    assign accept   = in_valid & in_ready;
    assign byte_acc = accept && state == S_RECV;
    assign start_ok = load_start && (state == S_IDLE || state == S_RUN || state == S_ERR);
    assign word_nx  = word_cnt + ONE;
    assign PC       = START_PC;

    loader_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .in_data    (in_data),
        .accept     (byte_acc),
        .word       (instructionInput),
        .word_ready (word_ready)
    );

`ifdef MIPS_LOADER_CHECKSUM_EN
    csum_t sum;

    // running modulo-256 sum of payload bytes, restarted by each accepted load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sum <= '0;
        else if (start_ok)
            sum <= '0;
        else if (byte_acc)
            sum <= sum + in_data;
    end
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // next-state logic; load requests outside IDLE/RUN/ERR fall through untouched
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_RUN, S_ERR:
                if (load_start)
                    state_nx = load_len > CAP ? S_ERR : load_len == '0 ? S_DONE : S_RECV;
            S_RECV:  state_nx = word_ready ? S_WRITE : S_RECV;
            S_WRITE: state_nx = word_nx == len_q ? S_DONE : S_RECV;
`ifdef MIPS_LOADER_CHECKSUM_EN
            S_CHK:   if (accept) state_nx = in_data == sum ? S_BOOT : S_ERR;
`endif
            S_BOOT:  state_nx = S_RUN;
            default: state_nx = S_IDLE;
        endcase
    end

    // outputs decoded from the state register only, so in_ready never depends on in_valid
    always_comb begin
        in_ready               = state == S_RECV;
`ifdef MIPS_LOADER_CHECKSUM_EN
        in_ready               = in_ready || state == S_CHK;
`endif
        instructionWriteEnable = state == S_WRITE;
        PC_set                 = state != S_RUN;
        busy                   = state == S_RECV || state == S_WRITE || state == S_CHK || state == S_BOOT;
        running                = state == S_RUN;
        error                  = state == S_ERR;
    end

    // word counter and write address: cleared by a load, advanced after each write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            word_cnt  <= '0;
            writeAddr <= '0;
        end else if (start_ok) begin
            len_q     <= load_len;
            word_cnt  <= '0;
            writeAddr <= '0;
        end else if (state == S_WRITE) begin
            word_cnt  <= word_nx;
            writeAddr <= writeAddr + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_mips_program_loader.sv
// tb_mips_program_loader: directed self-checking bench for the program loader
module tb_mips_program_loader;

    localparam int ADDR_W = 11;
`ifdef MIPS_LOADER_CHECKSUM_EN
    localparam int TAIL = 0;
`else
    localparam int TAIL = 1;
`endif

    logic              clk = 0;
    logic              rst_n = 0;
    logic              load_start = 0;
    logic [ADDR_W:0]   load_len = '0;
    logic [7:0]        in_data = '0;
    logic              in_valid = 0;
    logic              in_ready;
    logic [31:0]       instructionInput;
    logic              instructionWriteEnable;
    logic [ADDR_W-1:0] writeAddr;
    logic [31:0]       PC;
    logic              PC_set, busy, running, error;

    int checks = 0;
    int errors = 0;
    int overlap = 0;
    logic [ADDR_W-1:0] wa [$];
    logic [31:0]       wd [$];
    logic [7:0]        img [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    logic [7:0]        img1 [4] = '{8'h8C, 8'h09, 8'h00, 8'h04};

    mips_program_loader #(.ADDR_W(ADDR_W), .START_PC(32'h0000_0000)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .load_start             (load_start),
        .load_len               (load_len),
        .in_data                (in_data),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .instructionInput       (instructionInput),
        .instructionWriteEnable (instructionWriteEnable),
        .writeAddr              (writeAddr),
        .PC                     (PC),
        .PC_set                 (PC_set),
        .busy                   (busy),
        .running                (running),
        .error                  (error)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (instructionWriteEnable) begin
            wa.push_back(writeAddr);
            wd.push_back(instructionInput);
            if (in_ready) overlap++;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int len);
        load_len = (ADDR_W + 1)'(len);
        load_start = 1;
        step();
        load_start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        in_valid = 0;
        repeat (gap) step();
        in_data = b;
        in_valid = 1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        step();
        in_valid = 0;
    endtask

    task automatic send_img(input int maxgap);
        for (int i = 0; i < 8; i++) send_byte(img[i], $urandom_range(0, maxgap));
`ifdef MIPS_LOADER_CHECKSUM_EN
        send_byte(8'hC6, $urandom_range(0, maxgap));
`endif
    endtask

    task automatic expect_boot(input int pre, input string tag);
        repeat (pre) step();
        check({tag, "_boot_hold"}, PC_set, 1);
        step();
        check({tag, "_pc_set"}, PC_set, 0);
        check({tag, "_running"}, running, 1);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_img_writes(input string tag);
        logic [31:0] exp_d [2] = '{32'h2008_0005, 32'h8C09_0004};
        check({tag, "_wr_count"}, wa.size(), 2);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_wr_addr"}, i < wa.size() ? wa[i] : 'x, i);
            check({tag, "_wr_data"}, i < wd.size() ? wd[i] : 'x, exp_d[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_instr"}, instructionInput, 0);
        check({tag, "_we"}, instructionWriteEnable, 0);
        check({tag, "_addr"}, writeAddr, 0);
        check({tag, "_pc"}, PC, 32'h0);
        check({tag, "_pc_set"}, PC_set, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_running"}, running, 0);
        check({tag, "_error"}, error, 0);
    endtask

    initial begin
        #12;
        check_reset_outputs("rst");
        rst_n = 1;
        step();
        step();
        check_reset_outputs("idle");

        wa.delete(); wd.delete();
        load(2);
        check("l1_busy", busy, 1);
        check("l1_in_ready", in_ready, 1);
        check("l1_pc_set", PC_set, 1);
        send_img(0);
        expect_boot(TAIL, "l1");
        check_img_writes("l1");

        wa.delete(); wd.delete();
        load(2);
        check("rs_pc_set", PC_set, 1);
        check("rs_busy", busy, 1);
        check("rs_addr", writeAddr, 0);
        send_img(3);
        expect_boot(TAIL, "gap");
        check_img_writes("gap");
        check("we_while_ready", overlap, 0);

`ifdef MIPS_LOADER_CHECKSUM_EN
        wa.delete(); wd.delete();
        load(2);
        for (int i = 0; i < 8; i++) send_byte(img[i], 0);
        send_byte(8'hC7, 0);
        check("bad_error", error, 1);
        check("bad_pc_set", PC_set, 1);
        check("bad_running", running, 0);
        repeat (3) step();
        check("bad_error_hold", error, 1);
        check("bad_pc_hold", PC_set, 1);
        load(0);
        check("clr_error", error, 0);
        send_byte(8'h00, 0);
        expect_boot(0, "clr");
`endif

        wa.delete(); wd.delete();
        load(0);
        check("z_busy", busy, 1);
`ifdef MIPS_LOADER_CHECKSUM_EN
        check("z_chk_ready", in_ready, 1);
        send_byte(8'h00, 0);
`endif
        expect_boot(0, "z");
        check("z_wr_count", wa.size(), 0);

        load(2049);
        check("ovf_error", error, 1);
        check("ovf_busy", busy, 0);
        check("ovf_pc_set", PC_set, 1);
        check("ovf_in_ready", in_ready, 0);
        repeat (2) step();
        check("ovf_hold", error, 1);

        wa.delete(); wd.delete();
        load(2);
        check("mid_busy", busy, 1);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        rst_n = 0;
        #1;
        check_reset_outputs("mid");
        step();
        rst_n = 1;
        step();
        check_reset_outputs("mid_idle");
        check("mid_no_write", wa.size(), 0);

        load(1);
        for (int i = 0; i < 4; i++) send_byte(img1[i], 0);
`ifdef MIPS_LOADER_CHECKSUM_EN
        send_byte(8'h99, 0);
`endif
        expect_boot(TAIL, "fr");
        check("fr_wr_count", wa.size(), 1);
        check("fr_wr_addr", wa.size() > 0 ? wa[0] : 'x, 0);
        check("fr_wr_data", wd.size() > 0 ? wd[0] : 'x, 32'h8C09_0004);
        check("fr_error", error, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
